// File: rtl/ram_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the stereo line-buffer writer.
package ram_ctrl_pkg;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_DEPTH = 1024;
  localparam int DEF_DATA_WIDTH = 148;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SYNC = 2'd2;
endpackage

// File: rtl/ram_line_writer_if.sv
// Stream, write-port and sync signals between the line writer and its neighbours.
interface ram_line_writer_if #(
  parameter int ADDR_WIDTH = ram_ctrl_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = ram_ctrl_pkg::DEF_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0] cfg_line_words;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_ready;
  logic                  l_valid;
  logic [DATA_WIDTH-1:0] l_data;
  logic                  l_ready;
  logic                  rd_done;
  logic                  WRE;
  logic [ADDR_WIDTH-1:0] W_R_addr;
  logic [DATA_WIDTH-1:0] W_R_data;
  logic                  WLE;
  logic [ADDR_WIDTH-1:0] W_L_addr;
  logic [DATA_WIDTH-1:0] W_L_data;
  logic                  fsync;

  modport master (
    output cfg_line_words, r_valid, r_data, l_valid, l_data, rd_done,
    input  r_ready, l_ready, WRE, W_R_addr, W_R_data, WLE, W_L_addr, W_L_data, fsync
  );
  modport slave (
    input  cfg_line_words, r_valid, r_data, l_valid, l_data, rd_done,
    output r_ready, l_ready, WRE, W_R_addr, W_R_data, WLE, W_L_addr, W_L_data, fsync
  );
endinterface

// File: rtl/ram_side_writer.sv
// One stream side: word counter, ready generation and registered bank write port.
module ram_side_writer #(
  parameter int ADDR_WIDTH = ram_ctrl_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = ram_ctrl_pkg::DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill,
  input  logic                  clr,
  input  logic [ADDR_WIDTH:0]   line_len,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  full_next,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata
);
  logic [ADDR_WIDTH:0] cnt;
  logic [ADDR_WIDTH:0] cnt_next;
  logic                accept;

  assign ready     = fill && (cnt < line_len);
  assign accept    = valid && ready;
  assign cnt_next  = accept ? cnt + {{ADDR_WIDTH{1'b0}}, 1'b1} : cnt;
  // Lets the FSM leave FILL on the same edge that captures the final word.
  assign full_next = (cnt_next == line_len);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      we <= accept;
      if (accept) begin
        addr  <= cnt[ADDR_WIDTH-1:0];
        wdata <= data;
      end
      cnt <= clr ? '0 : cnt_next;
    end
  end
endmodule

// File: rtl/ram_line_writer.sv
// Feeds both sides of the rotating stereo line buffer and issues the bank-rotate fsync.
// Optional macro RAM_WRITER_STALL_CNT_EN adds stall_cycles and row_count outputs.
//
// state | meaning
// FILL  | accepting words on either side until both have a full row
// WAIT  | row complete, holding until the reader has released the previous set
// SYNC  | one-cycle fsync; counters cleared and row length reloaded
module ram_line_writer
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic clk,
  input  logic rst,
  ram_line_writer_if.slave bus
`ifdef RAM_WRITER_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] row_count
`endif
);
  localparam logic [ADDR_WIDTH:0] DEPTH_LEN = DATA_DEPTH[ADDR_WIDTH:0];

  logic [1:0]          state;
  logic [ADDR_WIDTH:0] line_len;
  logic [ADDR_WIDTH:0] cfg_len;
  logic                rd_seen;
  logic                fill;
  logic                clr;
  logic                r_full_next;
  logic                l_full_next;

  assign cfg_len   = (bus.cfg_line_words == '0) ? DEPTH_LEN : {1'b0, bus.cfg_line_words};
  assign fill      = (state == ST_FILL);
  assign clr       = (state == ST_SYNC);
  assign bus.fsync = clr;

  ram_side_writer #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_side_r (
    .clk(clk), .rst(rst), .fill(fill), .clr(clr), .line_len(line_len),
    .valid(bus.r_valid), .data(bus.r_data), .ready(bus.r_ready), .full_next(r_full_next),
    .we(bus.WRE), .addr(bus.W_R_addr), .wdata(bus.W_R_data)
  );

  ram_side_writer #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_side_l (
    .clk(clk), .rst(rst), .fill(fill), .clr(clr), .line_len(line_len),
    .valid(bus.l_valid), .data(bus.l_data), .ready(bus.l_ready), .full_next(l_full_next),
    .we(bus.WLE), .addr(bus.W_L_addr), .wdata(bus.W_L_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_FILL;
      line_len <= cfg_len;
      rd_seen  <= 1'b1;
    end else begin
      case (state)
        ST_FILL: if (r_full_next && l_full_next) state <= ST_WAIT;
        ST_WAIT: if (rd_seen || bus.rd_done) state <= ST_SYNC;
        default: begin
          state    <= ST_FILL;
          line_len <= cfg_len;
        end
      endcase
      // A release arriving alongside fsync counts toward the next row.
      if (bus.rd_done) rd_seen <= 1'b1;
      else if (clr)    rd_seen <= 1'b0;
    end
  end

`ifdef RAM_WRITER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      row_count    <= '0;
    end else begin
      if (state == ST_WAIT && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (clr) row_count <= row_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ram_line_writer.sv
// Directed and randomized bench for ram_line_writer against a row-level reference model.
module tb_ram_line_writer;
  import ram_ctrl_pkg::*;

  localparam int AW    = DEF_ADDR_WIDTH;
  localparam int DW    = DEF_DATA_WIDTH;
  localparam int DEPTH = DEF_DATA_DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_line_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef RAM_WRITER_STALL_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] row_count;
`endif

  ram_line_writer #(.ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RAM_WRITER_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .row_count(row_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int fsync_seen = 0;

  // Reference model: words taken per side this row, whether the row is still
  // filling, whether fsync is due this cycle, and whether the reader has released.
  int              m_rcnt, m_lcnt, m_len;
  bit              m_fill, m_sync, m_seen;
  logic            m_rwe, m_lwe;
  logic [AW-1:0]   m_raddr, m_laddr;
  logic [DW-1:0]   m_rdata, m_ldata;
  int              m_stall, m_rows;

  function automatic int len_of(input logic [AW-1:0] c);
    return (c == '0) ? DEPTH : int'(c);
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit rv, input bit lv, input bit rd);
    bus.r_valid = rv;
    bus.l_valid = lv;
    bus.rd_done = rd;
    bus.r_data  = rnd_word();
    bus.l_data  = rnd_word();
  endtask

  task automatic model_edge();
    bit racc, lacc, waiting, nsync;
    if (!rst) begin
      m_rcnt = 0; m_lcnt = 0; m_len = len_of(bus.cfg_line_words);
      m_fill = 1'b1; m_sync = 1'b0; m_seen = 1'b1;
      m_rwe = 1'b0; m_lwe = 1'b0; m_raddr = '0; m_laddr = '0; m_rdata = '0; m_ldata = '0;
      m_stall = 0; m_rows = 0;
      return;
    end
    racc    = bus.r_valid && m_fill && (m_rcnt < m_len);
    lacc    = bus.l_valid && m_fill && (m_lcnt < m_len);
    waiting = !m_fill && !m_sync;
    nsync   = 1'b0;
    m_rwe = racc;
    if (racc) begin m_raddr = AW'(m_rcnt); m_rdata = bus.r_data; m_rcnt++; end
    m_lwe = lacc;
    if (lacc) begin m_laddr = AW'(m_lcnt); m_ldata = bus.l_data; m_lcnt++; end
    if (waiting && m_stall < 65535) m_stall++;
    if (m_sync) m_rows = (m_rows + 1) % 65536;
    if (m_sync) begin
      m_rcnt = 0; m_lcnt = 0; m_len = len_of(bus.cfg_line_words); m_fill = 1'b1;
    end else if (m_fill) begin
      if (m_rcnt == m_len && m_lcnt == m_len) m_fill = 1'b0;
    end else begin
      nsync = m_seen || bus.rd_done;
    end
    if (bus.rd_done) m_seen = 1'b1;
    else if (m_sync) m_seen = 1'b0;
    m_sync = nsync;
  endtask

  // Compare all outputs at the negedge, then advance one clock and the model.
  task automatic cyc();
    chk("r_ready",  160'(bus.r_ready),  160'(m_fill && (m_rcnt < m_len)));
    chk("l_ready",  160'(bus.l_ready),  160'(m_fill && (m_lcnt < m_len)));
    chk("WRE",      160'(bus.WRE),      160'(m_rwe));
    chk("WLE",      160'(bus.WLE),      160'(m_lwe));
    chk("W_R_addr", 160'(bus.W_R_addr), 160'(m_raddr));
    chk("W_L_addr", 160'(bus.W_L_addr), 160'(m_laddr));
    chk("W_R_data", 160'(bus.W_R_data), 160'(m_rdata));
    chk("W_L_data", 160'(bus.W_L_data), 160'(m_ldata));
    chk("fsync",    160'(bus.fsync),    160'(m_sync));
`ifdef RAM_WRITER_STALL_CNT_EN
    chk("stall_cycles", 160'(stall_cycles), 160'(m_stall));
    chk("row_count",    160'(row_count),    160'(m_rows));
`endif
    if (bus.fsync === 1'b1) fsync_seen++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    bus.cfg_line_words = AW'(4);
    set_in(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc();
    rst = 1'b1;

    // Row 1: both sides back-to-back, first rotate needs no reader release.
    fsync_seen = 0;
    for (int i = 0; i < 10; i++) begin set_in(i < 4, i < 4, 1'b0); cyc(); end
    chk("row1_fsyncs", 160'(fsync_seen), 160'(1));

    // Left side lags the right by 10 cycles.
    fsync_seen = 0;
    for (int i = 0; i < 22; i++) begin set_in(i < 6, (i >= 10) && (i < 14), i == 0); cyc(); end
    chk("skew_fsyncs", 160'(fsync_seen), 160'(1));

    // Reader release withheld: row parks in WAIT until rd_done.
    fsync_seen = 0;
    for (int i = 0; i < 15; i++) begin set_in(i < 4, i < 4, 1'b0); cyc(); end
    chk("held_fsyncs", 160'(fsync_seen), 160'(0));
    set_in(1'b0, 1'b0, 1'b1); cyc();
    for (int i = 0; i < 3; i++) begin set_in(1'b0, 1'b0, 1'b0); cyc(); end
    chk("release_fsyncs", 160'(fsync_seen), 160'(1));

    // Release during FILL, and a release coincident with fsync carried to the next row.
    fsync_seen = 0;
    for (int i = 0; i < 10; i++) begin set_in(i < 4, i < 4, (i == 1) || m_sync); cyc(); end
    chk("early_rd_fsyncs", 160'(fsync_seen), 160'(1));
    fsync_seen = 0;
    for (int i = 0; i < 10; i++) begin set_in(i < 4, i < 4, 1'b0); cyc(); end
    chk("carried_rd_fsyncs", 160'(fsync_seen), 160'(1));

    // Randomized traffic, reader releases and mid-row configuration changes.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) bus.cfg_line_words = AW'($urandom_range(1, 6));
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      cyc();
    end

    // Zero length selects the full bank depth.
    rst = 1'b0;
    bus.cfg_line_words = '0;
    set_in(1'b0, 1'b0, 1'b0); cyc();
    rst = 1'b1;
    fsync_seen = 0;
    for (int i = 0; i < 1030; i++) begin set_in(1'b1, 1'b1, 1'b0); cyc(); end
    chk("full_depth_fsyncs", 160'(fsync_seen), 160'(1));

    // Reset mid-row discards the partial row.
    rst = 1'b0;
    bus.cfg_line_words = AW'(4);
    set_in(1'b0, 1'b0, 1'b0); cyc();
    rst = 1'b1;
    fsync_seen = 0;
    for (int i = 0; i < 2; i++) begin set_in(1'b1, 1'b1, 1'b0); cyc(); end
    rst = 1'b0;
    set_in(1'b1, 1'b1, 1'b0); cyc();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    chk("rst_WRE", 160'(bus.WRE), 160'(0));
    chk("rst_WLE", 160'(bus.WLE), 160'(0));
    cyc();
    chk("rst_fsyncs", 160'(fsync_seen), 160'(0));
    for (int i = 0; i < 10; i++) begin set_in(i < 4, i < 4, 1'b0); cyc(); end
    chk("post_rst_fsyncs", 160'(fsync_seen), 160'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
